uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver, the next generation of the team's fixed 8N1 receiver. Supports configurable data width, parity, stop-bit count, 3-sample majority bit decisions, false-start rejection, framing/parity/break/overrun detection, and a small receive FIFO. Sits between the board's serial RX pin and the command/hash-input parser, which consumes bytes through a valid/ready stream.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per bit (100 MHz / 115200). Minimum 8.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, `PAR_NONE`: `PAR_NONE`, `PAR_ODD` or `PAR_EVEN`.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: receive FIFO entries, power of 2, ≥2.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx` in 1: asynchronous serial line, idle high.
- `m_data` out `DATA_BITS`: FIFO head data, LSB received first.
- `m_frame_err` out 1: head entry had a bad stop bit.
- `m_parity_err` out 1: head entry failed parity (always 0 when `PAR_NONE`).
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: consumer accepts the head entry when `m_valid && m_ready`.
- `overrun` out 1: one-cycle pulse when a completed frame is dropped because the FIFO is full.
- `break_det` out 1: one-cycle pulse on a break condition.
- `busy` out 1: high in every state except IDLE.

## Operation
- Synchroniser: `rx` passes through a 2-flop synchroniser (`rx_s`). Both flops reset to 1.
- Bit counter `cnt` runs 0..`CLKS_PER_BIT`-1. `H` = `CLKS_PER_BIT`/2 (floor).
- Bit decision is a 2-of-3 majority of `rx_s` sampled at `cnt` = H-1, H, H+1. The decision is taken at `cnt` = H+1.
- States:
  - IDLE: a falling edge (`rx_s`=0, previous `rx_s`=1) moves to START with `cnt`=0.
  - START: if the decision is 1, it is a false start; return to IDLE, no output. Otherwise go to DATA at the wrap of `cnt`.
  - DATA: shift `DATA_BITS` decisions in LSB-first. Go to PARITY when `PARITY` ≠ `PAR_NONE`, else STOP.
  - PARITY: compare the decision with computed parity. Odd means data XOR parity bit = 1; even means it = 0.
  - STOP: on the first stop decision:
    - If 0, end the frame: a framing error, or a break (see below).
    - If 1 and `STOP_BITS`=2, wait for the second stop decision; a 0 there is a framing error.
    - The frame ends at the final decision cycle, without waiting out the rest of the bit.
  - WAIT_IDLE: entered after a framing error or break. Waits for `rx_s`=1, then goes to IDLE. No start is detected while in this state.
- Frame end, normal or framing error: push {data, frame_err, parity_err} to the FIFO. After a framing error, go to WAIT_IDLE; otherwise go to IDLE.
- Break: data all zero, parity decision 0 (if present), and first stop decision 0. Pulse `break_det`, push nothing, go to WAIT_IDLE.
- Overrun: a push while the FIFO is full and no pop occurs in the same cycle drops the new frame and pulses `overrun`. If a push and a pop coincide while full, both succeed and there is no overrun.
- `rst_n` low, including mid-frame: state goes to IDLE, FIFO empties, shift register clears. No partial frame is ever emitted.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_frame_err`=0, `m_parity_err`=0, `overrun`=0, `break_det`=0, `busy`=0.
- Let t0 be the cycle where IDLE detects the edge. Bit k (start = 0) is decided at t0+1+k·`CLKS_PER_BIT`+H+1.
- Pin-to-edge latency is 2 cycles (synchroniser) plus 1 cycle (edge register).
- `m_valid` rises 1 cycle after the final stop decision when the FIFO was empty.
- `overrun` and `break_det` assert in the cycle after the final decision.
- FIFO output is registered: `m_data`/flags are stable while `m_valid && !m_ready`. The next entry appears the cycle after a pop.
- Back-to-back frames: a start edge arriving ≥1 cycle after frame end is detected.

## Structure
- Package `uart_pkg` contains:
  - `uart_parity_e` (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`);
  - `uart_rx_state_e` (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - packed struct `uart_rx_entry_t` (data, frame_err, parity_err), maximum width 9 data bits.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) holds the receive FIFO. It is reused later by the planned transmitter.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- 8N1, send 0xA5 → `m_data`=0xA5, both error flags 0, `m_valid` at the computed cycle.
- 8E1, send 0x03 with parity bit 1 → entry 0x03 with `m_parity_err`=1. 7O2, send 0x41 with correct parity → no errors.
- Low glitch of 5 cycles on `rx` → `busy` returns to 0 by the start decision, no FIFO entry.
- 0x55 with stop bit 0, then line high → entry 0x55 with `m_frame_err`=1. The next frame 0x3C is received cleanly.
- Line low for 12 bit times, then 0x41 → one `break_det` pulse, no entry for the break, then an entry of 0x41.
- `FIFO_DEPTH`=4, `m_ready`=0, send 0x01..0x05 → `overrun` pulses once during frame 5. Raising `m_ready` yields 0x01..0x04 in order.
- Assert `rst_n` during data bit 3 of 0x7E → no entry. The following 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the parametrised UART receiver and its FIFO entries
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} uart_parity_e;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE} uart_rx_state_e;
  localparam int MAX_DATA_BITS = 9;
  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     frame_err;
    logic                     parity_err;
  } uart_rx_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small register-based FIFO whose head is always presented from storage
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign valid = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd_ptr];
  // storage, pointers and occupancy; a push into a full FIFO only lands if a pop frees a slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with majority voting, error flags and a receive FIFO
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int           CLKS_PER_BIT = 868,
  parameter int           DATA_BITS    = 8,
  parameter uart_parity_e PARITY       = PAR_NONE,
  parameter int           STOP_BITS    = 1,
  parameter int           FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_frame_err,
  output logic                 m_parity_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);
  localparam int H = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  uart_rx_state_e state, next;
  logic rx_m, rx_s, rx_d, s0, s1, par_bit;
  logic [CW-1:0] cnt;
  logic [3:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic dec, dec_at, wrap, push, brk, ferr, perr, is_break, full, unused_head;
  uart_rx_entry_t entry, head;
  assign dec = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign dec_at = cnt == CW'(H + 1);
  assign wrap = cnt == CW'(CLKS_PER_BIT - 1);
  assign perr = (PARITY != PAR_NONE) && ((^shreg ^ par_bit) != (PARITY == PAR_ODD));
  assign is_break = (shreg == '0) && (PARITY == PAR_NONE || !par_bit);
  assign entry = {MAX_DATA_BITS'(shreg), ferr, perr};
  assign busy = state != ST_IDLE;
  assign m_data = head.data[DATA_BITS-1:0];
  assign m_frame_err = head.frame_err;
  assign m_parity_err = head.parity_err;
  assign unused_head = ^head.data;
  // frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= next;
  end
  // next state plus the frame-end push/break strobes, all decided on the majority-vote cycle
  always_comb begin
    next = state;
    push = 1'b0;
    brk = 1'b0;
    ferr = 1'b0;
    case (state)
      ST_IDLE:      if (!rx_s && rx_d) next = ST_START;
      ST_START:     if (dec_at && dec) next = ST_IDLE; else if (wrap) next = ST_DATA;
      ST_DATA:      if (wrap && bit_idx == 4'(DATA_BITS - 1)) next = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY:    if (wrap) next = ST_STOP;
      ST_STOP: begin
        if (dec_at && !dec) begin
          next = ST_WAIT_IDLE;
          brk = bit_idx == '0 && is_break;
          push = !brk;
          ferr = 1'b1;
        end else if (dec_at && bit_idx == 4'(STOP_BITS - 1)) begin
          next = ST_IDLE;
          push = 1'b1;
        end
      end
      ST_WAIT_IDLE: if (rx_s) next = ST_IDLE;
      default:      next = ST_IDLE;
    endcase
  end
  // synchroniser, bit timing, vote samples, shift register and event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
      cnt <= '0;
      bit_idx <= '0;
      s0 <= 1'b1;
      s1 <= 1'b1;
      par_bit <= 1'b0;
      shreg <= '0;
      overrun <= 1'b0;
      break_det <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
      cnt <= (state == ST_IDLE || wrap) ? '0 : cnt + CW'(1);
      bit_idx <= (state == ST_IDLE || next != state) ? '0 : wrap ? bit_idx + 4'd1 : bit_idx;
      if (cnt == CW'(H - 1)) s0 <= rx_s;
      if (cnt == CW'(H)) s1 <= rx_s;
      if (state == ST_DATA && dec_at) shreg <= {dec, shreg[DATA_BITS-1:1]};
      if (state == ST_PARITY && dec_at) par_bit <= dec;
      overrun <= push && full && !(m_ready && m_valid);
      break_det <= brk;
    end
  end
  sync_fifo #(.WIDTH($bits(uart_rx_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (entry),
    .full      (full),
    .pop       (m_ready),
    .head      (head),
    .valid     (m_valid)
  );
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: drives three receiver configurations against a frame-level model
module tb_uart_rx_param;
  import uart_pkg::*;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx [3];
  logic rdy [3];
  logic val [3], fe [3], pe [3], ovr [3], brk [3], bsy [3];
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [8:0] dat [3];
  int total = 0, bad = 0, cyc = 0, rise_cyc = 0, t_send = 0;
  int ovr_cnt [3], brk_cnt [3], want_ovr [3], want_brk [3];
  int db [3] = '{8, 8, 7};
  int pm [3] = '{0, 2, 1};
  int sb [3] = '{1, 1, 2};
  logic [10:0] exq [3][$];
  logic pv0 = 1'b0;

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {1'b0, d1};
  assign dat[2] = {2'b0, d2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_param #(.CLKS_PER_BIT(CPB)) u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx[0]), .m_data(d0), .m_frame_err(fe[0]), .m_parity_err(pe[0]),
    .m_valid(val[0]), .m_ready(rdy[0]), .overrun(ovr[0]), .break_det(brk[0]), .busy(bsy[0]));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .PARITY(PAR_EVEN)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx[1]), .m_data(d1), .m_frame_err(fe[1]), .m_parity_err(pe[1]),
    .m_valid(val[1]), .m_ready(rdy[1]), .overrun(ovr[1]), .break_det(brk[1]), .busy(bsy[1]));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx[2]), .m_data(d2), .m_frame_err(fe[2]), .m_parity_err(pe[2]),
    .m_valid(val[2]), .m_ready(rdy[2]), .overrun(ovr[2]), .break_det(brk[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // frame-level model: build the serial bit list, predict entry/break/overrun, then drive the line
  task automatic send(input int u, input logic [8:0] d, input bit pflip, input bit serr, input int gap);
    logic [8:0] dm;
    bit par;
    logic b [$];
    dm = d & 9'((1 << db[u]) - 1);
    par = (^dm) ^ (pm[u] == 1) ^ pflip;
    b.push_back(1'b0);
    for (int i = 0; i < db[u]; i++) b.push_back(dm[i]);
    if (pm[u] != 0) b.push_back(par);
    b.push_back(!serr);
    if (sb[u] == 2) b.push_back(1'b1);
    if (serr && dm == 0 && (pm[u] == 0 || !par)) want_brk[u]++;
    else if (!rdy[u] && exq[u].size() >= 4) want_ovr[u]++;
    else exq[u].push_back({dm, serr, pflip && pm[u] != 0});
    @(negedge clk);
    t_send = cyc;
    foreach (b[i]) begin
      rx[u] = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx[u] = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (val[0] && !pv0) rise_cyc = cyc;
    pv0 = val[0];
    for (int u = 0; u < 3; u++) begin
      if (ovr[u]) ovr_cnt[u]++;
      if (brk[u]) brk_cnt[u]++;
      if (val[u] && rdy[u]) begin
        if (exq[u].size() == 0) chk($sformatf("extra_entry_u%0d", u), exq[u].size(), 1);
        else chk($sformatf("entry_u%0d", u), {dat[u], fe[u], pe[u]}, exq[u].pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 3; u++) begin
      rx[u] = 1'b1;
      rdy[u] = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("rst_valid", val[0], 0);
    chk("rst_data", dat[0], 0);
    chk("rst_ferr", fe[0], 0);
    chk("rst_perr", pe[0], 0);
    chk("rst_ovr", ovr[0], 0);
    chk("rst_brk", brk[0], 0);
    chk("rst_busy", bsy[0], 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send(0, 9'hA5, 0, 0, 10);
    chk("valid_latency", rise_cyc - t_send, 157);
    send(1, 9'h03, 1, 0, 10);
    send(2, 9'h41, 0, 0, 10);
    @(negedge clk);
    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_hi", bsy[0], 1);
    @(negedge clk);
    rx[0] = 1'b1;
    repeat (CPB) @(negedge clk);
    chk("glitch_busy_lo", bsy[0], 0);
    chk("glitch_no_entry", val[0], 0);
    send(0, 9'h55, 0, 1, 10);
    send(0, 9'h3C, 0, 0, 10);
    rx[0] = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    rx[0] = 1'b1;
    want_brk[0]++;
    repeat (20) @(negedge clk);
    send(0, 9'h41, 0, 0, 10);
    @(posedge clk) #1 rdy[0] = 1'b0;
    for (int i = 1; i <= 5; i++) send(0, 9'(i), 0, 0, 6);
    chk("ovr_count", ovr_cnt[0], want_ovr[0]);
    chk("head_hold", dat[0], 1);
    chk("full_valid", val[0], 1);
    @(posedge clk) #1 rdy[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("drained", exq[0].size(), 0);
    @(negedge clk);
    rx[0] = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    rx[0] = 1'b1;
    repeat (CPB + CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy", bsy[0], 0);
    chk("midrst_valid", val[0], 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send(0, 9'h81, 0, 0, 10);
    for (int n = 0; n < 30; n++) begin
      int u;
      logic [8:0] d;
      u = int'($urandom % 3);
      d = 9'($urandom);
      if ($urandom % 10 == 0) d = '0;
      send(u, d, pm[u] != 0 && ($urandom % 4 == 0), $urandom % 6 == 0, int'($urandom_range(4, 20)));
    end
    repeat (40) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("left_u%0d", u), exq[u].size(), 0);
      chk($sformatf("ovr_u%0d", u), ovr_cnt[u], want_ovr[u]);
      chk($sformatf("brk_u%0d", u), brk_cnt[u], want_brk[u]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
